// File: rtl/chip8_regfile_bulk.sv
// CHIP-8 V-register file with a bulk-transfer sequencer for FX55/FX65.
// It copies V0..Vx to or from memory at I over a req/ack handshake.
module chip8_regfile_bulk #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int MEM_AW   = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        flag_we,
    input  logic [DATA_W-1:0]           flag_data,
    input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
    output logic [DATA_W-1:0]           rdata_a,
    input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
    output logic [DATA_W-1:0]           rdata_b,
    input  logic                        bulk_start,
    input  logic                        bulk_load,
    input  logic [$clog2(NUM_REGS)-1:0] bulk_last,
    input  logic [MEM_AW-1:0]           bulk_base,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEM_AW-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack
);
    localparam int IW = $clog2(NUM_REGS);
    localparam logic [IW-1:0] FLAG_IDX = IW'(NUM_REGS - 1);

    // Memory handshake: a beat completes on every clock edge where mem_req and
    // mem_ack are both high; mem_req/mem_we/mem_addr/mem_wdata stay stable until then.
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [DATA_W-1:0] regs_n [NUM_REGS];
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_inc;
    logic [IW-1:0]     last;
    logic              load;

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign idx_inc = idx + IW'(1);

    // Next register contents; also used to source store data without a stale cycle.
    always_comb begin
        regs_n = regs;
        if (state == IDLE) begin
            if (we)      regs_n[waddr]    = wdata;
            if (flag_we) regs_n[FLAG_IDX] = flag_data;
        end else if (state == XFER && mem_ack && load) begin
            regs_n[idx] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            state     <= IDLE;
            idx       <= '0;
            last      <= '0;
            load      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            regs <= regs_n;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bulk_start) begin
                        state     <= XFER;
                        load      <= bulk_load;
                        last      <= bulk_last;
                        idx       <= '0;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= !bulk_load;
                        mem_addr  <= bulk_base;
                        mem_wdata <= bulk_load ? '0 : regs_n[0];
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        if (idx == last) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                        end else begin
                            idx       <= idx_inc;
                            mem_addr  <= mem_addr + MEM_AW'(1);
                            mem_wdata <= load ? '0 : regs_n[idx_inc];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_regfile_bulk.sv
// Bench for chip8_regfile_bulk: a behavioural register/transfer model checked every cycle,
// directed transfer scenarios with literal expectations, then randomized traffic.
module tb_chip8_regfile_bulk;
    localparam int DW = 8;
    localparam int NR = 16;
    localparam int AW = 12;

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0, flag_we = 1'b0, bulk_start = 1'b0, bulk_load = 1'b0;
    logic [3:0]    waddr = '0, raddr_a = '0, raddr_b = '0, bulk_last = '0;
    logic [DW-1:0] wdata = '0, flag_data = '0, rdata_a, rdata_b, mem_wdata, mem_rdata = '0;
    logic [AW-1:0] bulk_base = '0, mem_addr;
    logic          busy, done, mem_req, mem_we;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    chip8_regfile_bulk #(.DATA_W(DW), .NUM_REGS(NR), .MEM_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .we(we), .waddr(waddr), .wdata(wdata),
        .flag_we(flag_we), .flag_data(flag_data),
        .raddr_a(raddr_a), .rdata_a(rdata_a),
        .raddr_b(raddr_b), .rdata_b(rdata_b),
        .bulk_start(bulk_start), .bulk_load(bulk_load),
        .bulk_last(bulk_last), .bulk_base(bulk_base),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // ---------------- counters / check ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    // ack_mode 0: ack always high; 1: random 0..2 wait states (random ack when idle); 2: fixed 2 waits
    logic [DW-1:0] mem [4096];
    int ack_mode = 0;
    int wait_left = 0;
    bit hold_rd = 1'b0;

    always @(posedge clk) begin
        #1;
        if (ack_mode == 0) begin
            mem_ack = 1'b1;
        end else if (!mem_req) begin
            mem_ack   = (ack_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            wait_left = (ack_mode == 2) ? 2 : int'($urandom_range(0, 2));
        end else if (wait_left == 0) begin
            mem_ack   = 1'b1;
            wait_left = (ack_mode == 2) ? 2 : int'($urandom_range(0, 2));
        end else begin
            mem_ack = 1'b0;
            wait_left--;
        end
        mem_rdata = mem[mem_addr];
        if (!hold_rd) begin
            raddr_a = 4'($urandom_range(0, NR - 1));
            raddr_b = 4'($urandom_range(0, NR - 1));
        end
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [NR];
    bit m_active = 1'b0, m_fin = 1'b0, m_load = 1'b0;
    int m_k = 0, m_last = 0, m_base = 0;

    initial foreach (m_regs[i]) m_regs[i] = '0;

    always @(posedge clk) begin
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_active = 1'b0;
            m_fin    = 1'b0;
            m_k      = 0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_active) begin
            if (mem_ack) begin
                if (m_load) m_regs[m_k] = mem_rdata;
                if (m_k == m_last) begin
                    m_active = 1'b0;
                    m_fin    = 1'b1;
                end else begin
                    m_k++;
                end
            end
        end else begin
            if (we)      m_regs[waddr]  = wdata;
            if (flag_we) m_regs[NR - 1] = flag_data;
            if (bulk_start) begin
                m_active = 1'b1;
                m_k      = 0;
                m_load   = bulk_load;
                m_last   = int'(bulk_last);
                m_base   = int'(bulk_base);
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] wr_q[$];
    int busy_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata_a", rdata_a, m_regs[raddr_a]);
            chk("rdata_b", rdata_b, m_regs[raddr_b]);
            chk("busy", busy, m_active || m_fin);
            chk("done", done, m_fin);
            chk("mem_req", mem_req, m_active);
            if (m_active) begin
                chk("mem_we", mem_we, !m_load);
                chk("mem_addr", mem_addr, (m_base + m_k) % 4096);
                chk("mem_wdata", mem_wdata, m_load ? 0 : m_regs[m_k]);
            end
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (mem_req && mem_we && mem_ack) begin
                wr_q.push_back({mem_addr, mem_wdata});
                mem[mem_addr] = mem_wdata;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input int d);
        tick();
        we = 1'b1; waddr = 4'(a); wdata = 8'(d);
        tick();
        we = 1'b0;
    endtask

    task automatic start_bulk(input bit ld, input int last, input int base);
        tick();
        bulk_start = 1'b1; bulk_load = ld; bulk_last = 4'(last); bulk_base = 12'(base);
        tick();
        bulk_start = 1'b0;
    endtask

    task automatic rd_pair(input string name, input int ia, input int ea, input int ib, input int eb);
        @(negedge clk);
        #2;
        hold_rd = 1'b1;
        raddr_a = 4'(ia);
        raddr_b = 4'(ib);
        #1;
        chk({name, "_a"}, rdata_a, ea);
        chk({name, "_b"}, rdata_b, eb);
        hold_rd = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = c;
                break;
            end
        end
        if (at < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_writes(input string name);
        chk({name, "_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk(name, wr_q[i], exp_q[i]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int at;
        logic [DW-1:0] vals [NR];
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        for (int i = 0; i < NR; i += 2) rd_pair("rst_reg", i, 0, i + 1, 0);

        // basic writes, flag priority, independent dual write
        write_reg(3, 'h5A);
        rd_pair("wr_v3", 3, 'h5A, 3, 'h5A);
        tick();
        we = 1'b1; waddr = 4'd15; wdata = 8'h77; flag_we = 1'b1; flag_data = 8'h01;
        tick();
        we = 1'b0; flag_we = 1'b0;
        rd_pair("flag_wins", 15, 'h01, 15, 'h01);
        tick();
        we = 1'b1; waddr = 4'd4; wdata = 8'h44; flag_we = 1'b1; flag_data = 8'h99;
        tick();
        we = 1'b0; flag_we = 1'b0;
        rd_pair("dual_wr", 4, 'h44, 15, 'h99);

        // store FX55 with zero-wait memory
        write_reg(0, 'h11); write_reg(1, 'h22); write_reg(2, 'h33);
        ack_mode = 0;
        wr_q.delete(); busy_cnt = 0; done_cnt = 0;
        start_bulk(1'b0, 2, 'h300);
        wait_done(at);
        chk("store_done_at", at, 4);
        tick(); tick();
        chk("store_busy_cycles", busy_cnt, 4);
        chk("store_done_cnt", done_cnt, 1);
        exp_q = '{{12'h300, 8'h11}, {12'h301, 8'h22}, {12'h302, 8'h33}};
        check_writes("store_wr");

        // load FX65 with two wait states per beat
        mem[12'h200] = 8'hAB; mem[12'h201] = 8'hCD;
        ack_mode = 2;
        busy_cnt = 0; done_cnt = 0;
        start_bulk(1'b1, 1, 'h200);
        wait_done(at);
        chk("load_done_at", at, 7);
        tick(); tick();
        chk("load_busy_cycles", busy_cnt, 7);
        rd_pair("load_v01", 0, 'hAB, 1, 'hCD);
        rd_pair("load_v2", 2, 'h33, 2, 'h33);

        // full-range store with address wrap, random waits
        for (int i = 0; i < NR - 1; i++) begin
            vals[i] = 8'($urandom);
            write_reg(i, vals[i]);
        end
        vals[NR-1] = 8'($urandom);
        tick(); flag_we = 1'b1; flag_data = vals[NR-1];
        tick(); flag_we = 1'b0;
        ack_mode = 1;
        wr_q.delete(); exp_q.delete();
        for (int i = 0; i < NR; i++) exp_q.push_back({12'((12'hFFE + i) % 4096), vals[i]});
        start_bulk(1'b0, 15, 'hFFE);
        wait_done(at);
        tick();
        check_writes("wrap_wr");
        if (wr_q.size() == NR) begin
            chk("wrap_addr_2", wr_q[2][AW+DW-1:DW], 'h000);
            chk("wrap_last", wr_q[NR-1], {12'h00D, vals[NR-1]});
        end

        // writes and a second start during a transfer are dropped
        write_reg(5, 'h55);
        ack_mode = 0;
        wr_q.delete(); done_cnt = 0;
        start_bulk(1'b0, 7, 'h400);
        tick();
        we = 1'b1; waddr = 4'd5; wdata = 8'hEE; bulk_start = 1'b1; bulk_load = 1'b1;
        tick();
        we = 1'b0; bulk_start = 1'b0;
        wait_done(at);
        repeat (10) tick();
        chk("block_done_cnt", done_cnt, 1);
        chk("block_wr_count", wr_q.size(), 8);
        rd_pair("block_v5", 5, 'h55, 5, 'h55);

        // reset in the middle of a load
        mem[12'h100] = 8'h5C; mem[12'h101] = 8'h6D;
        ack_mode = 0;
        done_cnt = 0;
        start_bulk(1'b1, 3, 'h100);
        tick(); tick();
        reset = 1'b1;
        rd_pair("mid_load", 0, 'h5C, 1, 'h6D);
        tick();
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_busy", busy, 0);
        rd_pair("rst_mid_regs", 0, 0, 1, 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_mid_done_cnt", done_cnt, 0);

        // randomized traffic
        ack_mode = 1;
        for (int n = 0; n < 1500; n++) begin
            tick();
            reset      = ($urandom_range(0, 149) == 0);
            we         = 1'($urandom_range(0, 1));
            waddr      = 4'($urandom_range(0, NR - 1));
            wdata      = 8'($urandom);
            flag_we    = ($urandom_range(0, 3) == 0);
            flag_data  = 8'($urandom);
            bulk_start = ($urandom_range(0, 11) == 0);
            bulk_load  = 1'($urandom_range(0, 1));
            bulk_last  = 4'($urandom_range(0, NR - 1));
            bulk_base  = 12'($urandom);
        end
        tick();
        reset = 1'b0; we = 1'b0; flag_we = 1'b0; bulk_start = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/chip8_regfile_bulk.md
Name: chip8_regfile_bulk

Overview:
Parametrised successor of the CHIP-8 V-register file: NUM_REGS x DATA_W registers with one write port, two asynchronous read ports, and a dedicated flag-register (VF) write port. It adds a bulk-transfer sequencer for FX55/FX65. The sequencer copies V0..Vx to or from main memory starting at address I, over a req/ack handshake. It sits between the CPU datapath/decoder and the memory arbiter.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 16, number of registers (power of two, >=2); flag register is index NUM_REGS-1
MEM_AW, 12, memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
we  in  1  write enable, general port
waddr  in  log2(NUM_REGS)  write index
wdata  in  DATA_W  write data
flag_we  in  1  write enable for flag register
flag_data  in  DATA_W  flag write data
raddr_a  in  log2(NUM_REGS)  read index A
rdata_a  out  DATA_W  regs[raddr_a], combinational
raddr_b  in  log2(NUM_REGS)  read index B
rdata_b  out  DATA_W  regs[raddr_b], combinational
bulk_start  in  1  start bulk transfer (single-cycle pulse)
bulk_load  in  1  0 = store regs->mem (FX55), 1 = load mem->regs (FX65); sampled with bulk_start
bulk_last  in  log2(NUM_REGS)  last register index x, sampled with bulk_start
bulk_base  in  MEM_AW  base address I, sampled with bulk_start
busy  out  1  sequencer active
done  out  1  one-cycle pulse when transfer completes
mem_req  out  1  memory request
mem_we  out  1  1 = write (store), 0 = read (load)
mem_addr  out  MEM_AW  memory address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  request accepted/completed this cycle

Behaviour:
- Reset (sync): all regs 0; FSM to IDLE; busy, done, mem_req, mem_we = 0; mem_addr, mem_wdata = 0. Reset mid-transfer aborts with no further memory request from the next cycle. Registers loaded before the reset are cleared.
- Reads: asynchronous. No write-through: a value written at edge N is visible after edge N.
- Writes in IDLE:
  - we writes regs[waddr] <= wdata.
  - flag_we writes regs[NUM_REGS-1] <= flag_data.
  - If both target the flag register in the same cycle, flag_we wins.
  - If they target different registers, both writes occur.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - bulk_start captures bulk_load, bulk_last and bulk_base, sets idx=0, and moves to XFER. busy=1 from the next cycle.
  - we and flag_we in the same cycle as bulk_start still take effect.
- XFER:
  - mem_req=1, mem_we=!load, mem_addr=(base+idx) mod 2^MEM_AW, mem_wdata=regs[idx] when storing, else 0.
  - On a cycle with mem_ack=1:
    - Load: regs[idx] <= mem_rdata.
    - If idx==last, go to DONE; otherwise idx++.
  - mem_ack may arrive in the same cycle mem_req rises. Zero-wait memory therefore moves one register per cycle; x+1 registers take x+1 XFER cycles.
  - Wait states: outputs are held stable until ack.
- DONE: done=1 and busy=1 for one cycle, mem_req=0, then IDLE. busy goes low the cycle after done.
- While busy (XFER or DONE):
  - we, flag_we and bulk_start are ignored (dropped, not queued).
  - Read ports stay live and show partially loaded data.
- Boundaries:
  - bulk_last=0 transfers exactly V0.
  - bulk_last=NUM_REGS-1 includes the flag register.
  - The address wraps at 2^MEM_AW (base 0xFFE, x=3 gives 0xFFE, 0xFFF, 0x000, 0x001).
  - mem_ack outside XFER is ignored.

Test Plan:
- Reset/basic: after reset, rdata_a/b=0 for all indices. we waddr=3 wdata=0x5A, then raddr_a=3 -> 0x5A. Same cycle flag_we=0x01 and we waddr=15 wdata=0x77 -> VF=0x01.
- Store FX55: V0..V2={0x11,0x22,0x33}, bulk_start load=0 last=2 base=0x300, ack tied 1 -> three consecutive writes 0x300/0x11, 0x301/0x22, 0x302/0x33. done pulses on the 4th cycle after start; busy spans 4 cycles.
- Load FX65 with wait states: load=1 last=1 base=0x200, ack delayed 2 cycles per request, rdata {0xAB,0xCD} -> V0=0xAB, V1=0xCD, V2 unchanged. mem_addr is held during waits.
- Wrap and full range: base=0xFFE last=15 store -> addresses 0xFFE, 0xFFF, 0x000..0x00D; VF is written last.
- Busy blocking: we waddr=5 and a second bulk_start asserted mid-transfer -> V5 unchanged, exactly one done pulse.
- Reset mid-load: reset asserted after 2 of 4 acks -> mem_req=0, busy=0 next cycle, V0, V1=0, and no done pulse.
